btn_sw_conditioner: RTL
=======================

Name: btn_sw_conditioner

Overview:
Input-side front end for the board's push-buttons and slide switches. It is the receiving end of the btn/sw stimulus path that feeds the combinational logic tops.
- Synchronises each raw asynchronous input into the clk domain.
- Debounces each input with its own counter.
- Emits clean levels plus single-cycle press/release pulses, so downstream logic sees one event per physical actuation.

Parameters:
NUM_BTN, 4, number of push-button channels
NUM_SW, 8, number of slide-switch channels
BTN_DB_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz); minimum 1
SW_DB_CYCLES, 500000, same, for switch channels; minimum 1
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > max(BTN_DB_CYCLES, SW_DB_CYCLES)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
btn  input  NUM_BTN  raw push-buttons, asynchronous, active-high
sw  input  NUM_SW  raw slide switches, asynchronous
btn_db  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse on accepted 0->1 of btn_db
btn_release  output  NUM_BTN  one-cycle pulse on accepted 1->0 of btn_db
sw_db  output  NUM_SW  debounced switch levels
sw_change  output  1  one-cycle pulse when any sw_db bit changes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high. No asynchronous reset anywhere.
- Reset (rst=1 at a clk edge) clears:
  - all sync flops, counters and debounced states;
  - btn_db=0, btn_press=0, btn_release=0, sw_db=0, sw_change=0.
- Reset mid-operation discards any in-progress count; no pulse is emitted on the reset edge.
- Synchroniser: two flops per channel (s1 <= raw, s2 <= s1). Only s2 is used downstream.
- Per-channel debounce, with N = BTN_DB_CYCLES or SW_DB_CYCLES:
  - If s2 == state, cnt <= 0.
  - If s2 != state and cnt < N-1, cnt <= cnt+1.
  - If s2 != state and cnt == N-1, state <= s2 and cnt <= 0.
- Any return of s2 to the current state before acceptance restarts the count from 0. A glitch shorter than N cycles of s2 therefore never changes state.
- Latency: raw input changes before edge 1 and is captured by s1 at edge 1 and s2 at edge 2. The mismatch is counted on edges 3..N+2, and state flips on edge N+2. btn_db/sw_db are visible after edge N+2; total is N+2 cycles.
- Pulses:
  - btn_press[i] and btn_release[i] are registered on the same edge as the state flip.
  - Each is high for exactly one cycle, the cycle after edge N+2. They are mutually exclusive per channel.
  - sw_change goes high for one cycle if any sw channel flips on that edge.
- Channels are fully independent. Simultaneous flips on several channels produce simultaneous pulses on each. Each counter saturates only via the accept rule and never wraps.
- Input held high through reset release: the state is 0 after reset, so after N+2 cycles it is accepted and one press pulse is emitted. This is intended.
- Continuously toggling input with period < N cycles: state never changes and no pulses are emitted.
- N=1: a change is accepted on the first mismatch edge, giving latency 3 cycles.

Test Plan:
(Bench uses BTN_DB_CYCLES=4, SW_DB_CYCLES=4, 10 ns clk.)
1. Hold rst=1 for 5 cycles with btn=4'hF, sw=8'hFF -> all outputs 0 throughout reset. After release, btn_db=4'hF and sw_db=8'hFF exactly 6 edges later. btn_press=4'hF and sw_change=1 are each high for exactly one cycle.
2. btn[0] 0->1 held 20 cycles -> btn_db[0] rises after edge 6. btn_press[0] is high only in cycle 7; btn_release stays 0.
3. btn[1] glitches high for 3 cycles, low 1 cycle, high 3 cycles, then low -> btn_db[1] stays 0 and no pulses occur. Repeat with a 4-cycle high -> btn_db[1]=1 and one btn_press[1].
4. With btn_db[0]=1, release btn[0] -> btn_db[0] falls after 6 edges and btn_release[0] pulses once. Simultaneously press btn[2] on the same cycle -> btn_press[2] pulses in the same cycle as btn_release[0].
5. sw changes 8'h00 -> 8'h55 -> (after 10 cycles) 8'hF0 -> sw_db follows, each change 6 edges late. sw_change pulses exactly twice.
6. btn[3] held high, rst asserted for 1 cycle at edge 4 of the count -> outputs cleared and count restarted. btn_db[3] rises 6 edges after rst deasserts, with one btn_press[3].

Source files
------------

// File: rtl/btn_sw_conditioner.sv
// Push-button and slide-switch front end: two-flop synchronisers, per-channel
// debounce counters, clean levels and single-cycle press/release/change pulses.
module btn_sw_conditioner #(
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned NUM_SW        = 8,
    parameter int unsigned BTN_DB_CYCLES = 500000,
    parameter int unsigned SW_DB_CYCLES  = 500000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_db,
    output logic               sw_change
);

    localparam logic [CNT_W-1:0] BTN_LAST = CNT_W'(BTN_DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_DB_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_s1;
    logic [NUM_BTN-1:0] btn_s2;
    logic [NUM_BTN-1:0] btn_acc_c;
    logic [CNT_W-1:0]   btn_cnt [NUM_BTN];

    logic [NUM_SW-1:0]  sw_s1;
    logic [NUM_SW-1:0]  sw_s2;
    logic [NUM_SW-1:0]  sw_acc_c;
    logic [CNT_W-1:0]   sw_cnt [NUM_SW];

    // A channel is accepted on the edge that completes N consecutive mismatches.
    always_comb begin
        btn_acc_c = '0;
        sw_acc_c  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_acc_c[i] = (btn_s2[i] != btn_db[i]) && (btn_cnt[i] == BTN_LAST);
        end
        for (int i = 0; i < NUM_SW; i++) begin
            sw_acc_c[i] = (sw_s2[i] != sw_db[i]) && (sw_cnt[i] == SW_LAST);
        end
    end

    // Button synchroniser, counters, state and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1      <= '0;
            btn_s2      <= '0;
            btn_db      <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            btn_s1      <= btn;
            btn_s2      <= btn_s1;
            btn_press   <= btn_acc_c & btn_s2;
            btn_release <= btn_acc_c & ~btn_s2;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_s2[i] == btn_db[i] || btn_acc_c[i]) begin
                    btn_cnt[i] <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
                end
                if (btn_acc_c[i]) begin
                    btn_db[i] <= btn_s2[i];
                end
            end
        end
    end

    // Switch synchroniser, counters, state and change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            sw_db     <= '0;
            sw_change <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                sw_cnt[i] <= '0;
            end
        end else begin
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            sw_change <= |sw_acc_c;
            for (int i = 0; i < NUM_SW; i++) begin
                if (sw_s2[i] == sw_db[i] || sw_acc_c[i]) begin
                    sw_cnt[i] <= '0;
                end else begin
                    sw_cnt[i] <= sw_cnt[i] + CNT_W'(1);
                end
                if (sw_acc_c[i]) begin
                    sw_db[i] <= sw_s2[i];
                end
            end
        end
    end

endmodule
